// File: rtl/aes192_pkg.sv
// aes192_pkg: shared constants and types for the AES-192 key-schedule blocks.
//   NK / NR / WORDS : fixed AES-192 geometry (6 key words, 12 rounds, 52 words)
//   PTR_LOAD        : index of the first word of the final window (w46)
//   word_t          : 32-bit key-schedule word
//   rcon()          : round-constant byte for a word-group index 1..8
//   state_t         : inverse key-schedule FSM states
package aes192_pkg;

    localparam int unsigned NK       = 6;
    localparam int unsigned NR       = 12;
    localparam int unsigned WORDS    = 52;
    localparam int unsigned PTR_LOAD = WORDS - NK;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StStep
    } state_t;

    // Round constant for group index idx (= j / NK). Indices outside 1..8 never
    // reach the SubWord path, so they return zero.
    function automatic logic [7:0] rcon(input logic [5:0] idx);
        logic [7:0] rc;
        rc = 8'h00;
        case (idx)
            6'd1:    rc = 8'h01;
            6'd2:    rc = 8'h02;
            6'd3:    rc = 8'h04;
            6'd4:    rc = 8'h08;
            6'd5:    rc = 8'h10;
            6'd6:    rc = 8'h20;
            6'd7:    rc = 8'h40;
            6'd8:    rc = 8'h80;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_subword.sv
// aes_subword: combinational AES SubWord, four forward S-box lookups.
//   in_word  : 32-bit input word
//   out_word : S-box applied to each byte, byte positions preserved
module aes_subword
    import aes192_pkg::*;
(
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_word = {SBOX[in_word[31:24]], SBOX[in_word[23:16]],
                       SBOX[in_word[15:8]],  SBOX[in_word[7:0]]};

endmodule

// File: rtl/aes192_inv_key_sched.sv
// aes192_inv_key_sched: AES-192 key schedule run backwards, one word per cycle.
// Loads {w46..w51} and streams round keys 12 down to 0 over valid/ready.
//   clk, rst   : clock, synchronous active-high reset
//   start      : load request, accepted only in idle
//   key_in     : {w46..w51}, w46 in the MSBs
//   busy       : sequence in progress
//   out_valid  : round key presented; out_ready accepts it
//   out_key    : {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   out_round  : round index r
//   out_last   : marks round 0
//   done       : one-cycle pulse after the round-0 transfer
module aes192_inv_key_sched
    import aes192_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [191:0] key_in,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         out_last,
    output logic         done
);

    // win[i] holds w[p + i]
    word_t      win [NK];
    logic [5:0] p;
    state_t     state;

    logic [5:0] j;
    logic [5:0] p_dec;
    word_t      rot_word;
    word_t      sub_word;
    word_t      t_word;
    word_t      new_word;

    // j indexes win[5]; its predecessor w[j-1] sits in win[4]
    assign j        = p + 6'd5;
    assign p_dec    = p - 6'd1;
    assign rot_word = {win[4][23:0], win[4][31:24]};

    aes_subword u_subword (
        .in_word  (rot_word),
        .out_word (sub_word)
    );

    // Forward rule w[j] = w[j-6] ^ t(w[j-1]) inverted: w[j-6] = w[j] ^ t(w[j-1])
    always_comb begin
        t_word = win[4];
        if (j % 6'd6 == 6'd0) begin
            t_word = sub_word ^ {rcon(j / 6'd6), 24'h000000};
        end
        new_word = win[5] ^ t_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            p         <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_key   <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < NK; i++) begin
                win[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        for (int i = 0; i < NK; i++) begin
                            win[i] <= key_in[191 - 32*i -: 32];
                        end
                        p         <= 6'(PTR_LOAD);
                        // Round 12 is w48..w51, the top four words of the window
                        out_key   <= key_in[127:0];
                        out_round <= 4'(NR);
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= StEmit;
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_round == 4'd0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            state <= StStep;
                        end
                    end
                end
                StStep: begin
                    win[0] <= new_word;
                    for (int i = 1; i < NK; i++) begin
                        win[i] <= win[i-1];
                    end
                    p <= p_dec;
                    if (p_dec[1:0] == 2'b00) begin
                        // Round key is the low four words of the shifted window
                        out_key   <= {new_word, win[0], win[1], win[2]};
                        out_round <= p_dec[5:2];
                        out_last  <= (p_dec == 6'd0);
                        out_valid <= 1'b1;
                        state     <= StEmit;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes192_inv_key_sched.sv
// tb_aes192_inv_key_sched: scoreboard bench for the inverse AES-192 key schedule.
// The reference model expands the cipher key forwards with an S-box derived from
// GF(2^8) inversion plus the affine map; expected round keys are queued per run
// and a monitor pops and compares them on every transfer.
module tb_aes192_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [191:0] key_in;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         out_last;
    logic         done;

    aes192_inv_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_key   (out_key),
        .out_round (out_round),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    exp_t         exp_q [$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           done_count = 0;
    int           done_cyc = 0;
    int           fv_cyc [16];
    logic [127:0] cap_key [16];
    int           ready_mode = 0;

    logic [7:0]   sbox_m [256];
    logic [7:0]   rc_m [9];
    logic [31:0]  gw [52];

    localparam logic [191:0] FIPS_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] FIPS_R12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] FIPS_R0  = 128'h8e73b0f7da0e6452c810f32b809079e5;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        logic [7:0] y;
        r = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                        ^ 8'h63;
        end
        rc_m[0] = 8'h00;
        rc_m[1] = 8'h01;
        for (int i = 2; i < 9; i++) rc_m[i] = gmul(rc_m[i-1], 8'h02);
    endtask

    task automatic expand(input logic [191:0] key);
        logic [31:0] t;
        for (int i = 0; i < 6; i++) gw[i] = key[191 - 32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = gw[i-1];
            if (i % 6 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]}
                    ^ {rc_m[i/6], 24'h000000};
            end
            gw[i] = gw[i-6] ^ t;
        end
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else out_ready = ($urandom_range(0, 99) < 30);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t         e;
        logic         prev_valid;
        logic         hold_pending;
        logic [127:0] hold_key;
        logic [3:0]   hold_round;
        prev_valid   = 1'b0;
        hold_pending = 1'b0;
        hold_key     = '0;
        hold_round   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid   = 1'b0;
                hold_pending = 1'b0;
            end else begin
                if (out_valid && !prev_valid) fv_cyc[out_round] = cyc;
                prev_valid = out_valid;
                if (done) begin
                    done_count++;
                    done_cyc = cyc;
                end
                if (hold_pending && out_valid) begin
                    checks++;
                    if (out_key !== hold_key || out_round !== hold_round) begin
                        errors++;
                        $display("FAIL stall_hold: got round=%0d key=%h, required round=%0d key=%h",
                                 out_round, out_key, hold_round, hold_key);
                    end
                end
                hold_pending = out_valid && !out_ready;
                if (hold_pending) begin
                    hold_key   = out_key;
                    hold_round = out_round;
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL xfer_extra: got round=%0d key=%h, required no transfer",
                                 out_round, out_key);
                    end else begin
                        e = exp_q.pop_front();
                        cap_key[out_round] = out_key;
                        if (out_key !== e.key || out_round !== e.round || out_last !== e.last) begin
                            errors++;
                            $display("FAIL xfer: got round=%0d last=%b key=%h, required round=%0d last=%b key=%h",
                                     out_round, out_last, out_key, e.round, e.last, e.key);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic start_run(input logic [191:0] key, output int t0);
        expand(key);
        for (int r = 12; r >= 0; r--) begin
            exp_q.push_back('{key: {gw[4*r], gw[4*r+1], gw[4*r+2], gw[4*r+3]},
                              round: 4'(r), last: (r == 0)});
        end
        @(posedge clk);
        #1;
        key_in = {gw[46], gw[47], gw[48], gw[49], gw[50], gw[51]};
        start  = 1'b1;
        @(negedge clk);
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns in the done cycle (just after its negedge) so the next start lands
    // in the cycle right after done.
    task automatic wait_done(input int d0, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!done && k < 3000);
        check({name, "_done"}, 128'(done), 128'(1));
        check({name, "_done_count"}, 128'(done_count), 128'(d0 + 1));
        check({name, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
    endtask

    function automatic logic [191:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        int d0;
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        for (int i = 0; i < 16; i++) fv_cyc[i] = -1;
        build_tables();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 128'(out_valid), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_key", out_key, 128'(0));
        check("reset_round_last", 128'({out_round, out_last}), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // FIPS-197 A.2 vector, out_ready held high, exact timing
        ready_mode = 0;
        d0 = done_count;
        start_run(FIPS_KEY, t0);
        check("fips_busy", 128'(busy), 128'(1));
        wait_done(d0, "fips");
        check("fips_r12_key", cap_key[12], FIPS_R12);
        check("fips_r0_key", cap_key[0], FIPS_R0);
        check("fips_r12_cycle", 128'(fv_cyc[12]), 128'(t0 + 1));
        check("fips_r11_cycle", 128'(fv_cyc[11]), 128'(t0 + 4));
        check("fips_r5_cycle", 128'(fv_cyc[5]), 128'(t0 + 4 + 5 * 6));
        check("fips_r0_cycle", 128'(fv_cyc[0]), 128'(t0 + 59));
        check("fips_done_cycle", 128'(done_cyc), 128'(t0 + 60));

        // Back-to-back: next start in the cycle after done
        d0 = done_count;
        start_run(rand_key(), t0);
        wait_done(d0, "b2b");

        // Random backpressure with stray starts during the run
        ready_mode = 1;
        d0 = done_count;
        start_run(FIPS_KEY, t0);
        while (cyc < t0 + 10) begin @(posedge clk); #1; end
        key_in = rand_key();
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        while (cyc < t0 + 30) begin @(posedge clk); #1; end
        key_in = rand_key();
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        wait_done(d0, "stray_start");
        repeat (5) @(posedge clk);
        #1;
        check("stray_start_single_done", 128'(done_count), 128'(d0 + 1));

        // Mid-STEP reset aborts the run with no done
        ready_mode = 0;
        start_run(rand_key(), t0);
        while (cyc < t0 + 20) begin @(posedge clk); #1; end
        check("abort_busy_before", 128'(busy), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", 128'(out_valid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        rst = 1'b0;
        exp_q.delete();
        d0 = done_count;
        repeat (70) @(posedge clk);
        #1;
        check("abort_no_done", 128'(done_count), 128'(d0));
        d0 = done_count;
        start_run(FIPS_KEY, t0);
        wait_done(d0, "after_abort");

        // 200 random keys, half with random backpressure
        for (int n = 0; n < 200; n++) begin
            ready_mode = (n >= 100) ? 1 : 0;
            d0 = done_count;
            start_run(rand_key(), t0);
            wait_done(d0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
